stopwatch_counter: RTL and testbench
====================================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5000000, clk cycles per count increment (10 Hz at 50 MHz); legal range 2..2^26.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable-sample count required to accept a button level change; legal range 2..2^24.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port btn_start  input  1  raw start/stop button, asynchronous, active-high, may bounce.
REQ-006 SHALL have port btn_clear  input  1  raw clear button, asynchronous, active-high, may bounce.
REQ-007 SHALL have port btn_lap  input  1  raw lap button, asynchronous, active-high; functional only with LAP_HOLD_EN.
REQ-008 SHALL have port number  output  16  registered unsigned binary value 0..9999 for the 4-digit display driver.
REQ-009 SHALL have port running  output  1  registered, high when in state RUN.
REQ-010 SHALL have port overflow  output  1  registered sticky flag, set on 9999->0 wrap.

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-012 SHALL debounce each synchronized button: debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-013 SHALL generate a one-cycle registered press pulse on each debounced 0->1 transition; releases generate nothing.
REQ-014 SHALL act on a raw press held stable no later than DEBOUNCE_CYCLES+4 cycles after the raw edge.
REQ-015 SHALL implement states IDLE, RUN, PAUSE; start press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-016 SHALL, on clear press in any state, go to IDLE and zero count, prescaler and overflow in the same cycle.
REQ-017 SHALL give clear priority over a same-cycle start press; result is IDLE.
REQ-018 SHALL run the prescaler 0..TICK_DIV-1 only in RUN, emitting a tick on the cycle it equals TICK_DIV-1 and returning to 0 there.
REQ-019 SHALL hold the prescaler value in PAUSE, so resume continues the partial period; IDLE->RUN starts from 0.
REQ-020 SHALL increment count by 1 per tick; a tick at 9999 SHALL yield 0 and set overflow.
REQ-021 SHALL keep overflow set until clear or rst.
REQ-022 SHALL update number in the same cycle as count (no extra latency) unless held per REQ-027.
REQ-023 SHALL drive running = 1 exactly while state is RUN.
REQ-024 SHALL never present number > 9999.

Reset
REQ-025 SHALL, on rst high at a clk edge, set state IDLE, count 0, prescaler 0, number 0, running 0, overflow 0, synchronizers, debounce counters, debounced levels and press pulses 0, lap hold off.
REQ-026 SHALL let rst override all button activity, including mid-RUN and mid-debounce.

Configuration
REQ-027 SHALL implement lap-hold under macro STOPWATCH_LAP_HOLD_EN: a lap press in RUN or PAUSE toggles hold; while hold is on, number freezes and count keeps running; releasing hold reloads number from count on the next cycle; clear and rst release hold; lap in IDLE is ignored.
REQ-028 SHALL, without STOPWATCH_LAP_HOLD_EN, ignore btn_lap entirely (no lap logic synthesized) and always drive number from count.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=3)
REQ-029 SHALL verify start: after rst, btn_start held high 10 cycles -> running=1 within 7 cycles of raw edge; number 0,1,2,... stepping every 4 cycles.
REQ-030 SHALL verify bounce rejection: btn_start toggling every cycle for 20 cycles then low -> state stays IDLE, number=0.
REQ-031 SHALL verify wrap: count run to 9999, next tick -> number=0, overflow=1; overflow stays 1 for 100 further cycles.
REQ-032 SHALL verify pause/resume: pause at number=7 with prescaler=2 -> number=7 for 50 cycles; resume -> number=8 exactly 2 cycles after running returns to 1.
REQ-033 SHALL verify clear priority: start and clear debounced presses in the same cycle during RUN -> IDLE, number=0, overflow=0, running=0.
REQ-034 SHALL verify with STOPWATCH_LAP_HOLD_EN: lap press at number=5 -> number stays 5 for 40 cycles; second lap -> number=15 the next cycle (count advanced by 10 ticks).

Source files
------------

// File: rtl/stopwatch_counter.sv
// Stopwatch: synchronized, debounced start/stop, clear (and lap) buttons driving a 0..9999 tick counter.
// Define STOPWATCH_LAP_HOLD_EN to build the lap-hold display freeze; otherwise btn_lap is ignored.
module stopwatch_counter #(
    parameter int TICK_DIV        = 5000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [15:0] number,
    output logic        running,
    output logic        overflow
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
`ifdef STOPWATCH_LAP_HOLD_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int B_START = 0;
    localparam int B_CLEAR = 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2} state_t;

    logic [NB-1:0]         w_btn_raw;
    logic [NB-1:0]         r_sync1;
    logic [NB-1:0]         r_sync2;
    logic [NB-1:0]         r_level;
    logic [NB-1:0]         r_press;
    logic [NB-1:0][DW-1:0] r_db_cnt;

`ifdef STOPWATCH_LAP_HOLD_EN
    assign w_btn_raw = {btn_lap, btn_clear, btn_start};
`else
    logic w_unused_lap;
    assign w_unused_lap = btn_lap;
    assign w_btn_raw    = {btn_clear, btn_start};
`endif

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_level  <= '0;
            r_press  <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NB; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] == r_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_db_cnt[i] <= '0;
                    r_level[i]  <= r_sync2[i];
                    r_press[i]  <= r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                end
            end
        end
    end

    state_t      r_state;
    logic        r_running;
    logic        r_overflow;
    logic [PW-1:0] r_presc;
    logic [13:0] r_count;
    logic        w_start;
    logic        w_clear;
    logic        w_tick;
    logic        w_wrap;
    logic [13:0] w_count_next;

    assign w_start = r_press[B_START];
    assign w_clear = r_press[B_CLEAR];
    assign w_tick  = (r_state == S_RUN) && (r_presc == PW'(TICK_DIV - 1));
    assign w_wrap  = w_tick && (r_count == 14'd9999);

    always_comb begin
        w_count_next = r_count;
        if (w_clear || w_wrap) begin
            w_count_next = '0;
        end else if (w_tick) begin
            w_count_next = r_count + 14'd1;
        end
    end

    // Clear wins over a same-cycle start; the prescaler only moves while in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_running  <= 1'b0;
            r_presc    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (w_clear) begin
                r_state    <= S_IDLE;
                r_running  <= 1'b0;
                r_presc    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (r_state == S_RUN) begin
                    r_presc <= w_tick ? '0 : r_presc + PW'(1);
                end
                if (w_wrap) begin
                    r_overflow <= 1'b1;
                end
                if (w_start) begin
                    case (r_state)
                        S_IDLE, S_PAUSE: begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                        S_RUN: begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end
                        default: begin
                            r_state   <= S_IDLE;
                            r_running <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign running  = r_running;
    assign overflow = r_overflow;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        r_hold;
    logic        w_hold_next;
    logic [13:0] r_number;

    always_comb begin
        w_hold_next = r_hold;
        if (w_clear) begin
            w_hold_next = 1'b0;
        end else if (r_press[2] && (r_state != S_IDLE)) begin
            w_hold_next = ~r_hold;
        end
    end

    // While held the display keeps its last value; releasing reloads it from the live count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold   <= 1'b0;
            r_number <= '0;
        end else begin
            r_hold <= w_hold_next;
            if (!w_hold_next) begin
                r_number <= w_count_next;
            end
        end
    end

    assign number = {2'b00, r_number};
`else
    assign number = {2'b00, r_count};
`endif
endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: vector table, directed corner sequences, and random button
// activity checked every cycle against a run-time based reference model.
module tb_stopwatch_counter;
    localparam int TD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_lap = 1'b0;
    logic [15:0] number;
    logic        running;
    logic        overflow;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;
    bit found;

    stopwatch_counter #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .number(number), .running(running), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_lap = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press_start(input int hold);
        btn_start = 1'b1;
        repeat (hold) step();
        btn_start = 1'b0;
    endtask

    // Reference model: the display is elapsed RUN time divided into ticks.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_t;
    mstate_t     m_state;
    int          m_run;
    bit          m_hold;
    int          m_held;
    logic [2:0]  m_sync1, m_sync2, m_level, m_press;
    logic [DB-1:0] m_hist [3];

    function automatic int m_count();
        return (m_run / TD) % 10000;
    endfunction

    function automatic int m_number();
        return m_hold ? m_held : m_count();
    endfunction

    task automatic model_step();
        int old_num;
        if (rst) begin
            m_state = M_IDLE;
            m_run = 0;
            m_hold = 1'b0;
            m_held = 0;
            m_sync1 = '0;
            m_sync2 = '0;
            m_level = '0;
            m_press = '0;
            for (int b = 0; b < 3; b++) m_hist[b] = '0;
        end else begin
            old_num = m_number();
            if (m_press[1]) begin
                m_state = M_IDLE;
                m_run = 0;
                m_hold = 1'b0;
            end else begin
`ifdef STOPWATCH_LAP_HOLD_EN
                if (m_press[2] && m_state != M_IDLE) begin
                    m_hold = !m_hold;
                    if (m_hold) m_held = old_num;
                end
`endif
                if (m_state == M_RUN) m_run++;
                if (m_press[0]) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
            end
            for (int b = 0; b < 3; b++) begin
                m_hist[b] = {m_hist[b][DB-2:0], m_sync2[b]};
                m_press[b] = 1'b0;
                if (m_hist[b] == {DB{~m_level[b]}}) begin
                    m_level[b] = ~m_level[b];
                    m_press[b] = m_level[b];
                end
            end
            m_sync2 = m_sync1;
            m_sync1 = {btn_lap, btn_clear, btn_start};
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_number", 32'(number), 32'(m_number()));
            check("mdl_running", 32'(running), 32'(m_state == M_RUN));
            check("mdl_overflow", 32'(overflow), 32'(m_run >= 10000 * TD));
        end
    end

    typedef struct {
        logic        start;
        logic        clear;
        logic        exp_run;
        logic [15:0] exp_num;
    } vec_t;
    vec_t tbl [28];

    initial begin
        // Start held 10 cycles: RUN after edge 6, tick every 4 cycles; clear raised at edge 19 lands at edge 24.
        for (int k = 0; k < 28; k++) begin
            tbl[k].start   = (k < 10);
            tbl[k].clear   = (k >= 18);
            tbl[k].exp_run = (k >= 5) && (k < 23);
            tbl[k].exp_num = ((k >= 5) && (k < 23)) ? 16'((k - 5) / 4) : 16'd0;
        end

        do_reset();
        check("reset_number", 32'(number), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        chk_en = 1'b1;

        for (int k = 0; k < 28; k++) begin
            btn_start = tbl[k].start;
            btn_clear = tbl[k].clear;
            step();
            check("tbl_running", 32'(running), 32'(tbl[k].exp_run));
            check("tbl_number", 32'(number), 32'(tbl[k].exp_num));
        end
        btn_clear = 1'b0;
        repeat (10) step();

        // Bounce rejection
        do_reset();
        for (int i = 0; i < 20; i++) begin
            btn_start = ~btn_start;
            step();
        end
        btn_start = 1'b0;
        repeat (20) step();
        check("bounce_running", 32'(running), 32'd0);
        check("bounce_number", 32'(number), 32'd0);

        // Wrap 9999 -> 0 and sticky overflow
        do_reset();
        press_start(8);
        found = 1'b0;
        for (int i = 0; i < 41000 && !found; i++) begin
            step();
            if (number == 16'd9999) found = 1'b1;
        end
        if (!found) timeout_fail("wrap_reach_9999");
        check("wrap_ovf_before", 32'(overflow), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (number != 16'd9999) found = 1'b1;
        end
        if (!found) timeout_fail("wrap_next_tick");
        check("wrap_number", 32'(number), 32'd0);
        check("wrap_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 100; i++) begin
            step();
            check("wrap_ovf_sticky", 32'(overflow), 32'd1);
        end

        // Pause at number 7 with prescaler 2, then resume
        do_reset();
        btn_start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (running) found = 1'b1;
        end
        if (!found) timeout_fail("pause_start");
        step();
        step();
        btn_start = 1'b0;
        repeat (22) step();
        btn_start = 1'b1;
        repeat (6) step();
        check("pause_running", 32'(running), 32'd0);
        check("pause_number", 32'(number), 32'd7);
        step();
        step();
        btn_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            check("pause_hold", 32'(number), 32'd7);
        end
        btn_start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (running) found = 1'b1;
        end
        if (!found) timeout_fail("resume_running");
        check("resume_num_r0", 32'(number), 32'd7);
        step();
        check("resume_num_r1", 32'(number), 32'd7);
        step();
        check("resume_num_r2", 32'(number), 32'd8);
        btn_start = 1'b0;
        repeat (10) step();

        // Clear beats a same-cycle start during RUN
        do_reset();
        press_start(8);
        repeat (20) step();
        check("cp_running_before", 32'(running), 32'd1);
        btn_start = 1'b1;
        btn_clear = 1'b1;
        repeat (7) step();
        check("cp_running", 32'(running), 32'd0);
        check("cp_number", 32'(number), 32'd0);
        check("cp_overflow", 32'(overflow), 32'd0);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        repeat (10) step();
        check("cp_stays_idle", 32'(running), 32'd0);

`ifdef STOPWATCH_LAP_HOLD_EN
        // Lap hold: freeze at 5 while the count runs 10 more ticks
        do_reset();
        press_start(8);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (number == 16'd4) found = 1'b1;
        end
        if (!found) timeout_fail("lap_reach_4");
        btn_lap = 1'b1;
        repeat (6) step();
        for (int i = 0; i < 40; i++) begin
            if (i == 2) btn_lap = 1'b0;
            if (i == 34) btn_lap = 1'b1;
            check("lap_hold", 32'(number), 32'd5);
            step();
        end
        check("lap_release", 32'(number), 32'd15);
        btn_lap = 1'b0;
        repeat (10) step();
`endif

        // Random button activity, including occasional reset
        do_reset();
        for (int s = 0; s < 600; s++) begin
            int len;
            len = $urandom_range(1, 10);
            btn_start = 1'($urandom_range(0, 1));
            btn_clear = ($urandom_range(0, 15) == 0);
            btn_lap   = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            repeat (len) step();
        end
        rst = 1'b0;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_lap = 1'b0;
        repeat (10) step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
